// File: rtl/ddr_tx_pkg.sv
// rtl/ddr_tx_pkg.sv - shared word type and default parameters for the DDR transmitter
package ddr_tx_pkg;

   typedef logic [15:0] word_t;

   localparam int          DEFAULT_DEPTH     = 4;
   localparam logic [7:0]  DEFAULT_IDLE_BYTE = 8'h00;

endpackage

// File: rtl/ddr_tx_fifo.sv
// rtl/ddr_tx_fifo.sv - word FIFO feeding the DDR output stage
// Power-of-two depth lets the pointers wrap naturally.
module ddr_tx_fifo
   import ddr_tx_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  word_t                    push_data,
   input  logic                     pop,
   output word_t                    head,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PW = $clog2(DEPTH);

   word_t           mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;

   assign head = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/ddr_tx.sv
// rtl/ddr_tx.sv - FIFO-buffered DDR byte-lane transmitter, high byte in the high clock phase
// Optional parity lane enabled by macro DDR_TX_PARITY_EN.
module ddr_tx
   import ddr_tx_pkg::*;
#(
   parameter int          DEPTH     = DEFAULT_DEPTH,
   parameter logic [7:0]  IDLE_BYTE = DEFAULT_IDLE_BYTE
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [15:0]              in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     tx_en,
   output logic [7:0]               pin_data,
   output logic                     pin_strobe,
   output logic                     pin_parity,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int                LW      = $clog2(DEPTH) + 1;
   localparam logic [LW-1:0]     DEPTH_L = LW'(DEPTH);

   word_t       head;
   logic        push;
   logic        pop;
   logic [7:0]  hi_reg;
   logic [7:0]  lo_stage;
   logic [7:0]  lo_reg;
   logic        strobe_reg;

   assign in_ready = (level < DEPTH_L);
   assign push     = in_valid && in_ready;
   assign pop      = (level != '0) && tx_en;

   ddr_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (in_data),
      .pop       (pop),
      .head      (head),
      .level     (level)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_reg     <= IDLE_BYTE;
         lo_stage   <= IDLE_BYTE;
         strobe_reg <= 1'b0;
      end else if (pop) begin
         hi_reg     <= head[15:8];
         lo_stage   <= head[7:0];
         strobe_reg <= 1'b1;
      end else begin
         hi_reg     <= IDLE_BYTE;
         lo_stage   <= IDLE_BYTE;
         strobe_reg <= 1'b0;
      end
   end

   // Low byte crosses to the falling edge so it is stable for the whole low phase.
   always_ff @(negedge clk or posedge rst) begin
      if (rst)
         lo_reg <= IDLE_BYTE;
      else
         lo_reg <= lo_stage;
   end

   assign pin_data   = clk ? hi_reg : lo_reg;
   assign pin_strobe = strobe_reg;

`ifdef DDR_TX_PARITY_EN
   logic hi_par;
   logic lo_par_stage;
   logic lo_par;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_par       <= ^IDLE_BYTE;
         lo_par_stage <= ^IDLE_BYTE;
      end else if (pop) begin
         hi_par       <= ^head[15:8];
         lo_par_stage <= ^head[7:0];
      end else begin
         hi_par       <= ^IDLE_BYTE;
         lo_par_stage <= ^IDLE_BYTE;
      end
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst)
         lo_par <= ^IDLE_BYTE;
      else
         lo_par <= lo_par_stage;
   end

   assign pin_parity = clk ? hi_par : lo_par;
`else
   assign pin_parity = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_tx.sv
// tb/tb_ddr_tx.sv - self-checking bench for ddr_tx against a queue-based reference model
module tb_ddr_tx;

   localparam int         DEPTH = 4;
   localparam logic [7:0] IDLE  = 8'h00;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        tx_en;
   logic [7:0]  pin_data;
   logic        pin_strobe;
   logic        pin_parity;
   logic [2:0]  level;

   int n_assert = 0;
   int n_fail   = 0;

   logic [15:0] q[$];

   ddr_tx #(.DEPTH(DEPTH), .IDLE_BYTE(IDLE)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .tx_en      (tx_en),
      .pin_data   (pin_data),
      .pin_strobe (pin_strobe),
      .pin_parity (pin_parity),
      .level      (level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic par_of(input logic [7:0] b);
`ifdef DDR_TX_PARITY_EN
      return ^b;
`else
      return 1'b0 & b[0];
`endif
   endfunction

   // One clock period: apply inputs, then check both phases against the queue model.
   task automatic cycle(input logic v, input logic [15:0] d, input logic en);
      logic       popped;
      logic [15:0] w;
      logic [7:0] eh;
      logic [7:0] el;
      int         sz0;
      in_valid = v;
      in_data  = d;
      tx_en    = en;
      @(posedge clk);
      sz0    = q.size();
      popped = (sz0 > 0) && en;
      eh     = IDLE;
      el     = IDLE;
      if (popped) begin
         w  = q.pop_front();
         eh = w[15:8];
         el = w[7:0];
      end
      if (v && sz0 < DEPTH)
         q.push_back(d);
      #2;
      chk("pin_data_hi", 32'(pin_data), 32'(eh));
      chk("strobe_hi",   32'(pin_strobe), 32'(popped));
      chk("parity_hi",   32'(pin_parity), 32'(par_of(eh)));
      chk("level",       32'(level), 32'(q.size()));
      chk("in_ready",    32'(in_ready), 32'(q.size() < DEPTH));
      @(negedge clk);
      #2;
      chk("pin_data_lo", 32'(pin_data), 32'(el));
      chk("strobe_lo",   32'(pin_strobe), 32'(popped));
      chk("parity_lo",   32'(pin_parity), 32'(par_of(el)));
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      tx_en    = 1'b1;

      // reset state in both phases
      @(posedge clk); #2;
      chk("rst_data_hi", 32'(pin_data), 32'(IDLE));
      chk("rst_strobe",  32'(pin_strobe), 32'd0);
      chk("rst_ready",   32'(in_ready), 32'd1);
      chk("rst_level",   32'(level), 32'd0);
      chk("rst_parity",  32'(pin_parity), 32'(par_of(IDLE)));
      @(negedge clk); #2;
      chk("rst_data_lo", 32'(pin_data), 32'(IDLE));
      rst = 1'b0;

      cycle(1'b0, 16'h0, 1'b1);
      cycle(1'b0, 16'h0, 1'b1);

      // single word A55A
      cycle(1'b1, 16'hA55A, 1'b1);
      cycle(1'b0, 16'h0, 1'b1);
      cycle(1'b0, 16'h0, 1'b1);

      // fill while stalled: six offered, four accepted
      for (int i = 1; i <= 6; i++)
         cycle(1'b1, 16'(i), 1'b0);
      chk("full_level", 32'(level), 32'd4);
      chk("full_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < 5; i++)
         cycle(1'b0, 16'h0, 1'b1);

      // steady push/pop at level 2
      cycle(1'b1, 16'h1111, 1'b0);
      cycle(1'b1, 16'h2222, 1'b0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 16'($urandom), 1'b1);
         chk("steady_level", 32'(level), 32'd2);
      end
      cycle(1'b0, 16'h0, 1'b1);
      cycle(1'b0, 16'h0, 1'b1);

      // parity word
      cycle(1'b1, 16'h0103, 1'b1);
      cycle(1'b0, 16'h0, 1'b1);

      // random traffic
      for (int i = 0; i < 60; i++)
         cycle(1'($urandom), 16'($urandom), 1'($urandom_range(0, 3) != 0));

      // reset in the low phase of a word period
      cycle(1'b1, 16'hBEEF, 1'b0);
      cycle(1'b1, 16'hC0DE, 1'b0);
      cycle(1'b0, 16'h0, 1'b1);
      rst = 1'b1;
      #1;
      chk("mid_rst_data",   32'(pin_data), 32'(IDLE));
      chk("mid_rst_level",  32'(level), 32'd0);
      chk("mid_rst_strobe", 32'(pin_strobe), 32'd0);
      q.delete();
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++)
         cycle(1'b0, 16'h0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
